// File: rtl/async_fifo_burst_writer.sv
// Write-side burst producer for a 4-entry async FIFO: a 2-entry skid buffer feeds
// FIFO pushes in bursts that only start once the FIFO can take the whole burst.
module async_fifo_burst_writer #(
    parameter int unsigned FIFO_WIDTH = 32,
    parameter int unsigned BURST_LEN  = 2,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  writeClock,
    input  logic                  resetWriteS2,
    input  logic                  enable,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [FIFO_WIDTH-1:0] inData,
    input  logic                  inLast,
    output logic                  push,
    output logic [FIFO_WIDTH:0]   dataIn,
    input  logic                  fifoFull,
    output logic [2:0]            fullThreshold,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  wordCount,
    output logic [CNT_WIDTH-1:0]  pktCount
);

    // fifoFull==0 then means depth <= fullThreshold, so BURST_LEN more words always fit.
    localparam logic [2:0] FullThresh = 3'(4 - BURST_LEN);
    localparam logic [2:0] BurstInit  = 3'(BURST_LEN - 1);
    localparam bit         SingleBeat = (BURST_LEN == 1);

    typedef enum logic [0:0] {StIdle, StBurst} stateT;

    stateT                 stateQ, stateD;
    logic [2:0]            beatsLeftQ, beatsLeftD;
    logic [FIFO_WIDTH:0]   skidMemQ [2];
    logic                  rdPtrQ, wrPtrQ;
    logic [1:0]            skidCntQ;
    logic [CNT_WIDTH-1:0]  wordCountQ, pktCountQ;

    logic                  accept;
    logic                  skidNotEmpty;
    logic [FIFO_WIDTH:0]   head;
    logic                  headLast;

    assign skidNotEmpty  = (skidCntQ != 2'd0);
    assign inReady       = (skidCntQ != 2'd2);
    assign accept        = inValid && inReady;
    assign head          = skidMemQ[rdPtrQ];
    assign headLast      = head[FIFO_WIDTH];
    assign dataIn        = head;
    assign fullThreshold = FullThresh;
    assign busy          = (stateQ == StBurst) || skidNotEmpty;
    assign wordCount     = wordCountQ;
    assign pktCount      = pktCountQ;

    always_comb begin
        stateD     = stateQ;
        beatsLeftD = beatsLeftQ;
        push       = 1'b0;
        unique case (stateQ)
            StIdle: begin
                push = enable && skidNotEmpty && !fifoFull;
                if (push && !headLast && !SingleBeat) begin
                    stateD     = StBurst;
                    beatsLeftD = BurstInit;
                end
            end
            StBurst: begin
                // Room was reserved when the burst started, so fifoFull is ignored here.
                push = skidNotEmpty;
                if (push) begin
                    beatsLeftD = beatsLeftQ - 3'd1;
                    if (headLast || (beatsLeftQ == 3'd1)) begin
                        stateD = StIdle;
                    end
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge writeClock or negedge resetWriteS2) begin
        if (!resetWriteS2) begin
            stateQ     <= StIdle;
            beatsLeftQ <= 3'd0;
        end else begin
            stateQ     <= stateD;
            beatsLeftQ <= beatsLeftD;
        end
    end

    always_ff @(posedge writeClock or negedge resetWriteS2) begin
        if (!resetWriteS2) begin
            skidMemQ[0] <= '0;
            skidMemQ[1] <= '0;
            rdPtrQ      <= 1'b0;
            wrPtrQ      <= 1'b0;
            skidCntQ    <= 2'd0;
        end else begin
            if (accept) begin
                skidMemQ[wrPtrQ] <= {inLast, inData};
                wrPtrQ           <= ~wrPtrQ;
            end
            if (push) begin
                rdPtrQ <= ~rdPtrQ;
            end
            skidCntQ <= skidCntQ + {1'b0, accept} - {1'b0, push};
        end
    end

    always_ff @(posedge writeClock or negedge resetWriteS2) begin
        if (!resetWriteS2) begin
            wordCountQ <= '0;
            pktCountQ  <= '0;
        end else begin
            wordCountQ <= wordCountQ + {{(CNT_WIDTH-1){1'b0}}, push};
            pktCountQ  <= pktCountQ + {{(CNT_WIDTH-1){1'b0}}, push && headLast};
        end
    end

endmodule
